// File: rtl/mac_pkg.sv
// Shared types and helpers for the MAC tile host sequencer.
package mac_pkg;

    localparam int BEATS_MAX = 4;

    localparam logic MODE_INFER = 1'b0;
    localparam logic MODE_TRAIN = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PRIME,
        S_STREAM,
        S_WAIT,
        S_CAP_HI,
        S_CAP_LO,
        S_HOLD
    } state_t;

    function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] k);
        return word[{k, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/mac_result_deser.sv
// Assembles the MAC's two serialized byte pairs into a 32-bit result and
// holds it under a valid/ready handshake until the consumer takes it.
module mac_result_deser (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cap_hi,
    input  logic        cap_lo,
    input  logic [7:0]  uo_i,
    input  logic [7:0]  uio_i,
    input  logic        res_ready,
    output logic        res_valid,
    output logic [31:0] res_data
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            if (cap_hi) res_data[31:16] <= {uo_i, uio_i};
            if (cap_lo) res_data[15:0]  <= {uo_i, uio_i};
            if (cap_lo)
                res_valid <= 1'b1;
            else if (res_valid && res_ready)
                res_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mac_host_sequencer.sv
// Host-side pin driver for the iterative MAC tile: serializes one job's
// operands onto ui/uio and collects the 32-bit result back from uo/uio.
//
// state    | meaning
// IDLE     | ready for a job, MAC out of reset
// LOAD     | MAC held in reset while it samples {mode, act} on ui
// PRIME    | MAC released, weight byte 0 presented
// STREAM   | BEATS cycles of weight byte k on ui, bias byte k on uio
// WAIT     | uio bus turnaround, CAP_DELAY cycles
// CAP_HI   | capture result bytes 3:2 from uo/uio
// CAP_LO   | capture result bytes 1:0 from uo/uio
// HOLD     | result offered until res_ready
module mac_host_sequencer
    import mac_pkg::*;
#(
    parameter int CAP_DELAY = 1,
    parameter int BEATS     = BEATS_MAX
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic        job_mode,
    input  logic [6:0]  job_act,
    input  logic [31:0] job_weight,
    input  logic [31:0] job_bias,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        busy,
    output logic        mac_rst_n,
    output logic [7:0]  mac_ui,
    output logic [7:0]  mac_uio_o,
    output logic        mac_uio_oe,
    input  logic [7:0]  mac_uo_i,
    input  logic [7:0]  mac_uio_i
);

    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);
    // Only consulted when CAP_DELAY > 0; WAIT is skipped otherwise.
    localparam logic [2:0] WAIT_LOAD = 3'(CAP_DELAY - 1);

    state_t      state, state_nxt;
    logic [1:0]  beat;
    logic [2:0]  wait_cnt;
    logic        mode_q;
    logic [6:0]  act_q;
    logic [31:0] weight_q, bias_q;
    logic        cap_hi, cap_lo;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            beat     <= '0;
            wait_cnt <= '0;
            mode_q   <= MODE_INFER;
            act_q    <= '0;
            weight_q <= '0;
            bias_q   <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && job_valid) begin
                mode_q   <= job_mode;
                act_q    <= job_act;
                weight_q <= job_weight;
                bias_q   <= job_bias;
            end
            beat <= (state == S_STREAM && beat != LAST_BEAT) ? beat + 2'd1 : 2'd0;
            if (state == S_STREAM)
                wait_cnt <= WAIT_LOAD;
            else if (state == S_WAIT && wait_cnt != 3'd0)
                wait_cnt <= wait_cnt - 3'd1;
        end
    end

    always_comb begin
        state_nxt  = state;
        job_ready  = 1'b0;
        busy       = 1'b1;
        mac_rst_n  = rst_n;
        mac_ui     = '0;
        mac_uio_o  = '0;
        mac_uio_oe = 1'b0;
        cap_hi     = 1'b0;
        cap_lo     = 1'b0;
        case (state)
            S_IDLE: begin
                job_ready = 1'b1;
                busy      = 1'b0;
                if (job_valid) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                mac_rst_n = 1'b0;
                mac_ui    = {mode_q, act_q};
                state_nxt = S_PRIME;
            end
            S_PRIME: begin
                mac_ui    = byte_of(weight_q, 2'd0);
                state_nxt = S_STREAM;
            end
            S_STREAM: begin
                mac_ui     = byte_of(weight_q, beat);
                mac_uio_o  = byte_of(bias_q, beat);
                mac_uio_oe = 1'b1;
                if (beat == LAST_BEAT)
                    state_nxt = (CAP_DELAY == 0) ? S_CAP_HI : S_WAIT;
            end
            S_WAIT: begin
                mac_ui = byte_of(weight_q, LAST_BEAT);
                if (wait_cnt == 3'd0) state_nxt = S_CAP_HI;
            end
            S_CAP_HI: begin
                mac_ui    = byte_of(weight_q, LAST_BEAT);
                cap_hi    = 1'b1;
                state_nxt = S_CAP_LO;
            end
            S_CAP_LO: begin
                mac_ui    = byte_of(weight_q, LAST_BEAT);
                cap_lo    = 1'b1;
                state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (res_valid && res_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    mac_result_deser u_deser (
        .clk       (clk),
        .rst_n     (rst_n),
        .cap_hi    (cap_hi),
        .cap_lo    (cap_lo),
        .uo_i      (mac_uo_i),
        .uio_i     (mac_uio_i),
        .res_ready (res_ready),
        .res_valid (res_valid),
        .res_data  (res_data)
    );

endmodule

// File: tb/tb_mac_host_sequencer.sv
// Self-checking bench for mac_host_sequencer: a job-level timeline model
// checked every cycle, plus hand-computed pin and result expectations.
module tb_mac_host_sequencer;

    localparam int CAP  = 1;
    localparam int NB   = 4;
    localparam int T_HI = 2 + NB + CAP;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        job_valid = 1'b0;
    logic        job_mode = 1'b0;
    logic [6:0]  job_act = '0;
    logic [31:0] job_weight = '0;
    logic [31:0] job_bias = '0;
    logic        res_ready = 1'b0;
    logic [7:0]  mac_uo_i = '0;
    logic [7:0]  mac_uio_i = '0;
    logic        job_ready, res_valid, busy, mac_rst_n, mac_uio_oe;
    logic [31:0] res_data;
    logic [7:0]  mac_ui, mac_uio_o;

    always #5 clk = ~clk;

    mac_host_sequencer #(.CAP_DELAY(CAP), .BEATS(NB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .job_valid  (job_valid),
        .job_ready  (job_ready),
        .job_mode   (job_mode),
        .job_act    (job_act),
        .job_weight (job_weight),
        .job_bias   (job_bias),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .busy       (busy),
        .mac_rst_n  (mac_rst_n),
        .mac_ui     (mac_ui),
        .mac_uio_o  (mac_uio_o),
        .mac_uio_oe (mac_uio_oe),
        .mac_uo_i   (mac_uo_i),
        .mac_uio_i  (mac_uio_i)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Job-level model: t counts clock edges since the job was accepted.
    logic        chk_en = 1'b0;
    logic        m_busy = 1'b0, m_valid = 1'b0, m_in_rst = 1'b0;
    logic        m_mode = 1'b0;
    logic [6:0]  m_act = '0;
    logic [31:0] m_w = '0, m_b = '0, m_res = '0, m_data = '0;
    logic [31:0] mac_result = '0;
    int          t = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            chk_en   <= 1'b1;
            m_in_rst <= 1'b1;
            m_busy   <= 1'b0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            t        <= 0;
        end else begin
            m_in_rst <= 1'b0;
            if (!m_busy) begin
                if (job_valid) begin
                    m_busy <= 1'b1;
                    t      <= 0;
                    m_mode <= job_mode;
                    m_act  <= job_act;
                    m_w    <= job_weight;
                    m_b    <= job_bias;
                    m_res  <= mac_result;
                end
            end else if (m_valid) begin
                if (res_ready) begin
                    m_busy  <= 1'b0;
                    m_valid <= 1'b0;
                end
            end else begin
                if (t == T_HI) m_data[31:16] <= {mac_uo_i, mac_uio_i};
                if (t == T_HI + 1) begin
                    m_data[15:0] <= {mac_uo_i, mac_uio_i};
                    m_valid      <= 1'b1;
                end
                t <= t + 1;
            end
        end
    end

    // MAC tile stand-in: result bytes only in the two capture cycles, filler elsewhere.
    always @(posedge clk) begin
        #1;
        if (m_busy && !m_valid && t == T_HI)
            {mac_uo_i, mac_uio_i} = m_res[31:16];
        else if (m_busy && !m_valid && t == T_HI + 1)
            {mac_uo_i, mac_uio_i} = m_res[15:0];
        else
            {mac_uo_i, mac_uio_i} = 16'h5AA5;
    end

    function automatic logic [7:0] exp_ui(input int tt);
        if (tt == 0) return {m_mode, m_act};
        if (tt == 1) return m_w[7:0];
        if (tt < 2 + NB) return 8'(m_w >> (8 * (tt - 2)));
        return 8'(m_w >> (8 * (NB - 1)));
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            logic in_job;
            in_job = m_busy && !m_valid;
            chk("job_ready", 32'(job_ready), 32'(!m_busy));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("res_valid", 32'(res_valid), 32'(m_valid));
            chk("res_data", res_data, m_data);
            chk("mac_rst_n", 32'(mac_rst_n), 32'(rst_n && !(in_job && t == 0)));
            chk("mac_uio_oe", 32'(mac_uio_oe), 32'(in_job && t >= 2 && t < 2 + NB));
            if (in_job && t <= 1 + NB + CAP)
                chk("mac_ui", 32'(mac_ui), 32'(exp_ui(t)));
            if (in_job && t >= 2 && t < 2 + NB)
                chk("mac_uio_o", 32'(mac_uio_o), 32'(8'(m_b >> (8 * (t - 2)))));
            if (!m_busy && m_in_rst) begin
                chk("rst_mac_ui", 32'(mac_ui), 32'h0);
                chk("rst_mac_uio_o", 32'(mac_uio_o), 32'h0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic m, input logic [6:0] a, input logic [31:0] w,
                         input logic [31:0] b, input logic [31:0] r);
        job_mode   = m;
        job_act    = a;
        job_weight = w;
        job_bias   = b;
        mac_result = r;
        job_valid  = 1'b1;
    endtask

    task automatic scramble_job();
        job_valid  = 1'b0;
        job_mode   = ~job_mode;
        job_act    = '1;
        job_weight = '1;
        job_bias   = '1;
    endtask

    logic [7:0] lit_ui  [7]  = '{8'h03, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    logic [7:0] lit_uio [4]  = '{8'h44, 8'h33, 8'h22, 8'h11};
    logic       lit_oe  [10] = '{0, 0, 1, 1, 1, 1, 0, 0, 0, 0};

    initial begin
        logic [7:0] obs_ui [10];
        logic [7:0] obs_uio [10];
        logic       obs_oe [10];
        logic       obs_v [10];
        int lat;
        int vcount;

        rst_n = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("reset_mac_rst_n", 32'(mac_rst_n), 32'h0);
        chk("reset_job_ready", 32'(job_ready), 32'h1);
        chk("reset_res_valid", 32'(res_valid), 32'h0);
        chk("reset_oe", 32'(mac_uio_oe), 32'h0);
        chk("reset_res_data", res_data, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // Inference job with hand-computed pin sequence.
        offer(1'b0, 7'h03, 32'h04030201, 32'h11223344, 32'hDEADBEEF);
        tick();
        scramble_job();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            obs_ui[i]  = mac_ui;
            obs_uio[i] = mac_uio_o;
            obs_oe[i]  = mac_uio_oe;
            obs_v[i]   = res_valid;
        end
        for (int i = 0; i < 7; i++) chk($sformatf("seq_ui[%0d]", i), 32'(obs_ui[i]), 32'(lit_ui[i]));
        for (int i = 0; i < 4; i++) chk($sformatf("seq_uio[%0d]", i), 32'(obs_uio[i+2]), 32'(lit_uio[i]));
        for (int i = 0; i < 10; i++) chk($sformatf("seq_oe[%0d]", i), 32'(obs_oe[i]), 32'(lit_oe[i]));
        for (int i = 0; i < 10; i++) chk($sformatf("seq_valid[%0d]", i), 32'(obs_v[i]), 32'(i == 9));
        chk("result_job1", res_data, 32'hDEADBEEF);

        // Back-pressure with a training job already offered.
        tick();
        offer(1'b1, 7'h7F, 32'hA1B2C3D4, 32'h0F1E2D3C, 32'h12345678);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_res_data", res_data, 32'hDEADBEEF);
            chk("bp_job_ready", 32'(job_ready), 32'h0);
            chk("bp_no_load", 32'(mac_rst_n), 32'h1);
            chk("bp_res_valid", 32'(res_valid), 32'h1);
            tick();
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        @(negedge clk);
        chk("after_hs_job_ready", 32'(job_ready), 32'h1);
        chk("after_hs_res_valid", 32'(res_valid), 32'h0);
        tick();
        scramble_job();
        @(negedge clk);
        chk("train_load_ui", 32'(mac_ui), 32'hFF);
        chk("train_load_rst", 32'(mac_rst_n), 32'h0);
        lat = 0;
        while (!res_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("train_latency", 32'(lat), 32'd9);
        chk("result_job2", res_data, 32'h12345678);
        tick();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // Reset asserted during stream beat 2.
        offer(1'b0, 7'h55, 32'hCAFEF00D, 32'h01020304, 32'h99999999);
        tick();
        scramble_job();
        repeat (4) tick();
        chk("pre_abort_oe", 32'(mac_uio_oe), 32'h1);
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        chk("abort_oe", 32'(mac_uio_oe), 32'h0);
        chk("abort_mac_rst_n", 32'(mac_rst_n), 32'h0);
        chk("abort_job_ready", 32'(job_ready), 32'h1);
        chk("abort_busy", 32'(busy), 32'h0);
        tick();
        rst_n = 1'b1;
        vcount = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (res_valid) vcount++;
        end
        chk("abort_no_result", 32'(vcount), 32'h0);

        // Training job taken immediately by a ready consumer.
        tick();
        res_ready = 1'b1;
        offer(1'b1, 7'h2A, 32'h00FF00FF, 32'hFF00FF00, 32'h0BADF00D);
        tick();
        scramble_job();
        lat = 0;
        @(negedge clk);
        while (!res_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("job4_latency", 32'(lat), 32'd9);
        chk("result_job4", res_data, 32'h0BADF00D);
        tick();
        @(negedge clk);
        chk("job4_released", 32'(res_valid), 32'h0);
        chk("job4_idle", 32'(job_ready), 32'h1);
        res_ready = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mac_host_sequencer.md
Name: mac_host_sequencer

Overview:
- Host-side driver for the iterative MAC tile's pin protocol. It transmits operands over the MAC's ui/uio pins and collects the serialized 32-bit result from its uo/uio pins.
- It accepts one job per valid/ready transaction and returns one result per valid/ready transaction.
- It sits between a job source (test controller or FPGA-side logic) and the MAC's pin interface.

Parameters:
- CAP_DELAY, 1, cycles between the last operand beat and the first result capture (range 0-7).
- BEATS, 4, operand byte beats per job (weight/bias bytes); fixed at 4 for a 32-bit accumulator.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- job_valid  in  1  job offered
- job_ready  out  1  sequencer accepts job
- job_mode  in  1  0 = inference, 1 = training
- job_act  in  7  input activation
- job_weight  in  32  weight bytes, byte 0 = [7:0]
- job_bias  in  32  bias bytes, byte 0 = [7:0]
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- res_data  out  32  captured result
- busy  out  1  high in any state except IDLE
- mac_rst_n  out  1  reset to MAC tile
- mac_ui  out  8  MAC dedicated inputs
- mac_uio_o  out  8  bias byte driven toward MAC
- mac_uio_oe  out  1  host drive enable on the uio bus
- mac_uo_i  in  8  MAC uo pins
- mac_uio_i  in  8  MAC uio pins (result byte while MAC drives)

Behaviour:
- Reset (rst_n=0) forces the following, synchronously, from any state:
  - state = IDLE
  - job_ready=1, res_valid=0, res_data=0, busy=0
  - mac_rst_n=0, mac_ui=0, mac_uio_o=0, mac_uio_oe=0
- States: IDLE, LOAD, PRIME, STREAM, WAIT, CAP_HI, CAP_LO, HOLD.
- IDLE:
  - job_ready=1, mac_rst_n=1.
  - job_valid & job_ready latches all job fields and moves to LOAD. job_ready drops the next cycle.
- LOAD (1 cycle): mac_rst_n=0, mac_ui={mode, act}. The MAC samples mode and activation here.
- PRIME (1 cycle): mac_rst_n=1, mac_ui=weight byte 0, mac_uio_oe=0.
- STREAM (BEATS cycles):
  - beat counter k runs 0..BEATS-1.
  - mac_ui = weight byte k; mac_uio_o = bias byte k; mac_uio_oe=1.
  - Counter wraps to 0 on exit.
- WAIT:
  - mac_uio_oe=0 (bus turnaround); mac_ui holds weight byte BEATS-1.
  - Lasts CAP_DELAY cycles. With CAP_DELAY=0, STREAM goes directly to CAP_HI, but mac_uio_oe is still 0 in CAP_HI.
- CAP_HI: res_data[31:24] <= mac_uo_i, res_data[23:16] <= mac_uio_i.
- CAP_LO: res_data[15:8] <= mac_uo_i, res_data[7:0] <= mac_uio_i. Next state is HOLD.
- HOLD:
  - res_valid=1; res_data stays stable while res_valid=1 and res_ready=0.
  - res_valid & res_ready returns to IDLE, with res_valid=0 the following cycle.
- Latency: job accept to res_valid = 1 + 1 + BEATS + CAP_DELAY + 2 cycles, i.e. 9 with defaults.
- Throughput: one job in flight. job_ready=0 in every state except IDLE; no queueing.
- Accept and result handshake are never simultaneous, because job_ready is only high in IDLE.
- The uio bus is never driven by the host (mac_uio_oe=1) in LOAD, PRIME, WAIT, CAP_HI or CAP_LO.
- Training mode uses the same pin sequence. Early termination inside the MAC does not alter host timing.
- Reset mid-operation aborts the job and any held result is discarded. No res_valid pulse is produced.
- Inputs are sampled only at accept; job_* changes after acceptance have no effect.

Decomposition:
- Shared package mac_pkg holds:
  - state enum
  - BEATS_MAX=4
  - mode encodings MODE_INFER=0, MODE_TRAIN=1
  - byte-lane select function byte_of(word, k)
- Natural sub-module: mac_result_deser. It captures two byte pairs into the 32-bit res_data and owns the res_valid/res_ready hold register.
- The FSM and operand serializer stay in the top.

Test Plan:
- Reset and idle: hold rst_n=0 for 3 cycles -> mac_rst_n=0, job_ready=1, res_valid=0, mac_uio_oe=0, res_data=0.
- Operand sequence: job mode=0, act=0x03, weight=0x04030201, bias=0x11223344, CAP_DELAY=1.
  - LOAD: mac_ui=0x03.
  - PRIME: mac_ui=0x01.
  - STREAM: mac_ui = 0x01, 0x02, 0x03, 0x04 with mac_uio_o = 0x44, 0x33, 0x22, 0x11 and oe=1 each beat.
  - WAIT: oe=0.
- Result capture: the MAC model returns (uo, uio) = (0xDE, 0xAD) in CAP_HI and (0xBE, 0xEF) in CAP_LO -> res_data=0xDEADBEEF, res_valid exactly 9 cycles after accept.
- Back-pressure: hold res_ready=0 for 5 cycles with job_valid=1 -> res_data stable, job_ready=0, no new LOAD. Raising res_ready -> IDLE, new job accepted the next cycle.
- Training mode: job_mode=1, act=0x7F -> LOAD drives mac_ui=0xFF; the rest of the pin timing is identical to inference.
- Reset mid-STREAM: assert rst_n=0 at beat 2 -> next cycle mac_uio_oe=0, mac_rst_n=0, state IDLE. No res_valid ever appears for the aborted job.
